// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer.
//   - redirect mode encodings carried on the mode input
//   - sequencer state enum
//   - helper for the alignment field width of a target address
package pc_pkg;

    localparam logic [1:0] MODE_ABS  = 2'b00;
    localparam logic [1:0] MODE_REL  = 2'b01;
    localparam logic [1:0] MODE_CALL = 2'b10;
    localparam logic [1:0] MODE_RET  = 2'b11;

    typedef enum logic {
        PC_RUN  = 1'b0,
        PC_HALT = 1'b1
    } pc_state_e;

    // Alignment field width for the default 4-byte instruction size.
    localparam int PC_ALIGN_W = $clog2(4);

    // Number of low address bits that must be zero for a target to be
    // aligned to a power-of-two instruction size.
    function automatic int align_w(input int instr_bytes);
        return $clog2(instr_bytes);
    endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack.
// Ports:
//   clk, rst   clock and asynchronous active-high reset (pointer/count only)
//   push, pop  stack operations; never asserted together by the sequencer
//   din        address pushed
//   dout       current top of stack (valid when empty=0)
//   full       count == RAS_DEPTH
//   empty      count == 0
// A push while full overwrites the oldest entry, which is the slot the
// write pointer has wrapped onto; the count saturates at RAS_DEPTH.
module pc_ras #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] din,
    output logic [XLEN-1:0] dout,
    output logic            full,
    output logic            empty
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = $clog2(RAS_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(RAS_DEPTH);

    logic [XLEN-1:0] mem_q [RAS_DEPTH];
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   top_idx;

    // ptr_q points at the next free slot; the top is the slot below it.
    assign top_idx = ptr_q - 1'b1;
    assign dout    = mem_q[top_idx];
    assign full    = (cnt_q == DEPTH_C);
    assign empty   = (cnt_q == '0);

    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (push) begin
            ptr_d = ptr_q + 1'b1;
            if (cnt_q != DEPTH_C) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (pop && (cnt_q != '0)) begin
            ptr_d = ptr_q - 1'b1;
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    // Entry storage needs no reset: the count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[ptr_q] <= din;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter with redirects and a return-address stack.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   we, stall    advance enable; stall overrides we
//   imm, mode    redirect request and kind (abs, rel, call, ret)
//   imm_addr     absolute target or signed offset
//   instr_addr   current PC (registered)
//   halt, err    sticky halt and its cause (err=1 fault, err=0 end of memory)
//   ras_full, ras_empty  return-address stack occupancy
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_VEC   = '0,
    parameter int              INSTR_BYTES = 4,
    parameter int              MEM_BYTES   = 1024,
    parameter int              RAS_DEPTH   = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic            stall,
    input  logic            imm,
    input  logic [1:0]      mode,
    input  logic [XLEN-1:0] imm_addr,
    output logic [XLEN-1:0] instr_addr,
    output logic            halt,
    output logic            err,
    output logic            ras_full,
    output logic            ras_empty
);

    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((1 << align_w(INSTR_BYTES)) - 1);
    localparam logic [XLEN:0]   MEM_LIMIT  = (XLEN + 1)'(MEM_BYTES);

    pc_state_e       state_q;
    logic [XLEN-1:0] pc_q;
    logic            err_q;

    logic [XLEN-1:0] seq_pc;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] ras_top;
    logic            advance;
    logic            is_call, is_ret;
    logic            underflow, misalign, out_of_mem, fault;
    logic            ras_push, ras_pop;

    assign advance = (state_q == PC_RUN) && we && !stall;
    assign seq_pc  = pc_q + XLEN'(INSTR_BYTES);
    assign is_call = imm && (mode == MODE_CALL);
    assign is_ret  = imm && (mode == MODE_RET);

    always_comb begin
        target = seq_pc;
        if (imm) begin
            case (mode)
                MODE_ABS: target = imm_addr;
                MODE_REL: target = pc_q + imm_addr;
                MODE_CALL: target = pc_q + imm_addr;
                default: target = ras_top;
            endcase
        end
    end

    // Underflow outranks the other checks since ras_top is meaningless then.
    assign underflow  = is_ret && ras_empty;
    assign misalign   = (target & ALIGN_MASK) != '0;
    assign out_of_mem = {1'b0, target} >= MEM_LIMIT;
    assign fault      = underflow || misalign || out_of_mem;

    // The stack only moves on a redirect that actually commits.
    assign ras_push = advance && is_call && !fault;
    assign ras_pop  = advance && is_ret && !fault;

    pc_ras #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .rst   (rst),
        .push  (ras_push),
        .pop   (ras_pop),
        .din   (seq_pc),
        .dout  (ras_top),
        .full  (ras_full),
        .empty (ras_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= PC_RUN;
            pc_q    <= RESET_VEC;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                PC_RUN: begin
                    if (advance) begin
                        if (fault) begin
                            state_q <= PC_HALT;
                            err_q   <= underflow || misalign;
                        end else begin
                            pc_q <= target;
                        end
                    end
                end
                default: begin
                    state_q <= PC_HALT;
                end
            endcase
        end
    end

    assign instr_addr = pc_q;
    assign halt       = (state_q == PC_HALT);
    assign err        = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        we = 1'b0, stall = 1'b0, imm = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [31:0] imm_addr = '0;
    logic [31:0] instr_addr;
    logic        halt, err, ras_full, ras_empty;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic        m_halt, m_err;
    logic [31:0] m_ras[$];

    pc_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .we         (we),
        .stall      (stall),
        .imm        (imm),
        .mode       (mode),
        .imm_addr   (imm_addr),
        .instr_addr (instr_addr),
        .halt       (halt),
        .err        (err),
        .ras_full   (ras_full),
        .ras_empty  (ras_empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic compare_all();
        chk("pc", instr_addr, m_pc);
        chk("halt", 32'(halt), 32'(m_halt));
        if (m_halt) chk("err", 32'(err), 32'(m_err));
        chk("ras_empty", 32'(ras_empty), 32'(m_ras.size() == 0));
        chk("ras_full", 32'(ras_full), 32'(m_ras.size() == 4));
    endtask

    // Behavioural model of one clock edge, computed from the architectural rules.
    task automatic model_step();
        logic [31:0] t;
        if (m_halt || !we || stall) return;
        if (imm && mode == 2'd3 && m_ras.size() == 0) begin
            m_halt = 1'b1; m_err = 1'b1; return;
        end
        if (!imm)              t = m_pc + 32'd4;
        else if (mode == 2'd0) t = imm_addr;
        else if (mode == 2'd3) t = m_ras[$];
        else                   t = m_pc + imm_addr;
        if (t % 4 != 0) begin
            m_halt = 1'b1; m_err = 1'b1;
        end else if (t >= 32'd1024) begin
            m_halt = 1'b1; m_err = 1'b0;
        end else begin
            if (imm && mode == 2'd2) begin
                m_ras.push_back(m_pc + 32'd4);
                if (m_ras.size() > 4) void'(m_ras.pop_front());
            end
            if (imm && mode == 2'd3) void'(m_ras.pop_back());
            m_pc = t;
        end
    endtask

    task automatic cycle(input logic w, input logic s, input logic i,
                         input logic [1:0] md, input logic [31:0] a);
        we = w; stall = s; imm = i; mode = md; imm_addr = a;
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        we = 0; stall = 0; imm = 0; mode = 0; imm_addr = 0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        m_pc = 32'h0; m_halt = 1'b0; m_err = 1'b0; m_ras.delete();
        compare_all();
        rst = 1'b0;
    endtask

    logic [31:0] ra;
    logic [1:0]  rm;

    initial begin
        m_pc = 0; m_halt = 0; m_err = 0;

        // 1: sequential fetch out of reset
        do_reset();
        chk("reset_pc", instr_addr, 32'h0);
        for (int k = 0; k < 3; k++) cycle(1, 0, 0, 2'd0, 0);
        chk("seq_0xC", instr_addr, 32'hC);
        cycle(1, 0, 0, 2'd0, 0);

        // 2: stalled redirect is dropped, then accepted
        cycle(1, 1, 1, 2'd0, 32'h40);
        chk("stall_hold", instr_addr, 32'h10);
        cycle(1, 0, 1, 2'd0, 32'h40);
        chk("abs_0x40", instr_addr, 32'h40);

        // 3: call with negative offset and matching return
        cycle(1, 0, 1, 2'd2, 32'hFFFF_FFF0);
        chk("call_0x30", instr_addr, 32'h30);
        cycle(1, 0, 1, 2'd3, 0);
        chk("ret_0x44", instr_addr, 32'h44);
        chk("ret_empty", 32'(ras_empty), 32'd1);

        // 4: RAS overflow then underflow
        do_reset();
        for (int k = 0; k < 5; k++) cycle(1, 0, 1, 2'd2, 32'h8);
        chk("ras_full5", 32'(ras_full), 32'd1);
        for (int k = 0; k < 4; k++) begin
            cycle(1, 0, 1, 2'd3, 0);
            chk("ret_seq", instr_addr, 32'h24 - 32'(k * 8));
        end
        cycle(1, 0, 1, 2'd3, 0);
        chk("underflow_halt", 32'(halt), 32'd1);
        chk("underflow_err", 32'(err), 32'd1);

        // 5: misaligned target, absorbing halt, asynchronous reset
        do_reset();
        cycle(1, 0, 0, 2'd0, 0);
        cycle(1, 0, 1, 2'd0, 32'h6);
        chk("misalign_pc", instr_addr, 32'h4);
        for (int k = 0; k < 4; k++)
            cycle(k[0], k[1], ~k[0], 2'(k), 32'h100);
        rst = 1'b1;
        #2;
        chk("async_rst_pc", instr_addr, 32'h0);
        chk("async_rst_halt", 32'(halt), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        m_pc = 0; m_halt = 0; m_err = 0; m_ras.delete();

        // 6: end of memory
        cycle(1, 0, 1, 2'd0, 32'h3F8);
        cycle(1, 0, 0, 2'd0, 0);
        chk("eom_0x3FC", instr_addr, 32'h3FC);
        cycle(1, 0, 0, 2'd0, 0);
        chk("eom_halt", 32'(halt), 32'd1);
        chk("eom_err", 32'(err), 32'd0);
        chk("eom_pc", instr_addr, 32'h3FC);

        // Randomized phase against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if (m_halt && $urandom_range(0, 3) == 0) do_reset();
            rm = 2'($urandom_range(0, 3));
            case (rm)
                2'd0: ra = 32'($urandom_range(0, 270)) * 32'd4;
                2'd3: ra = $urandom;
                default: ra = 32'($urandom_range(0, 64)) * 32'd4 - 32'd128;
            endcase
            if ($urandom_range(0, 15) == 0) ra = ra + 32'($urandom_range(1, 3));
            cycle($urandom_range(0, 9) < 8, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 9) < 3, rm, ra);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised next-generation program counter for the RISCV-32 core fetch stage.
- Holds the current instruction address and advances it by INSTR_BYTES per enabled cycle.
- Supports absolute, PC-relative, call and return redirects; calls and returns use an internal return-address stack (RAS).
- Raises a sticky halt on end-of-memory, misaligned target or RAS underflow; only reset clears it.

Parameters:
XLEN, 32, address width in bits
RESET_VEC, 0, instr_addr value after reset
INSTR_BYTES, 4, sequential increment and required target alignment (power of two)
MEM_BYTES, 1024, instruction memory size; a target >= MEM_BYTES halts
RAS_DEPTH, 4, return-address stack entries (>=2, power of two)

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
we  in  1  advance enable; when 0 the PC holds
stall  in  1  pipeline stall; when 1 the PC holds; overrides we
imm  in  1  redirect request this cycle
mode  in  2  redirect kind: 00 absolute, 01 relative, 10 call, 11 return
imm_addr  in  XLEN  absolute target, or signed offset for relative/call
instr_addr  out  XLEN  current PC, registered
halt  out  1  sticky halt, registered
err  out  1  sticky error cause flag, valid while halt=1
ras_full  out  1  RAS holds RAS_DEPTH entries
ras_empty  out  1  RAS holds no entries

Behaviour:
- Reset, asynchronous: instr_addr=RESET_VEC, halt=0, err=0, RAS cleared (ras_empty=1, ras_full=0), state=RUN.
- States are RUN and HALT.
  - RUN→HALT on a qualifying fault.
  - HALT is absorbing: instr_addr and RAS are frozen and all inputs are ignored until rst.
- Advance condition: state=RUN, we=1 and stall=0. Otherwise every register holds.
- Target selection on an advance, one-cycle latency; new instr_addr is visible after the edge:
  - imm=0: pc+INSTR_BYTES.
  - mode 00: imm_addr.
  - mode 01: pc+imm_addr, two's complement, modulo 2^XLEN.
  - mode 10: pc+imm_addr, and pc+INSTR_BYTES is pushed onto the RAS.
  - mode 11: RAS top is popped and used as the target.
- mode is ignored when imm=0.
- Fault checks on the computed target, in priority order:
  1. Return with ras_empty=1: halt=1, err=1, PC holds.
  2. Target not a multiple of INSTR_BYTES: halt=1, err=1, PC holds, no push.
  3. Target >= MEM_BYTES, unsigned: halt=1, err=0 (normal end of program), PC holds, no push.
- Fault checks apply to sequential increments too, including wrap past 2^XLEN, which lands at a low address and is legal if in range.
- The halt update is registered: halt rises on the same edge on which the PC would have updated.
- RAS behaviour:
  - Circular LIFO.
  - A push while full overwrites the oldest entry; the count stays RAS_DEPTH and ras_full stays 1.
  - ras_full and ras_empty are derived from a registered count (0..RAS_DEPTH).
- Simultaneous rst with any other input: rst wins.
- rst asserted mid-operation clears state immediately, without waiting for clk.
- stall=1 together with imm=1: the redirect is dropped and not queued. The requester must hold imm until it is accepted.

Decomposition:
- Package pc_pkg:
  - mode encodings MODE_ABS, MODE_REL, MODE_CALL, MODE_RET.
  - state enum PC_RUN, PC_HALT.
  - localparam for alignment mask width clog2(INSTR_BYTES).
- Sub-module pc_ras (params XLEN, RAS_DEPTH; ports clk, rst, push, pop, din, dout, full, empty):
  - Circular pointer plus count.
  - Push and pop are never asserted together by pc_sequencer.

Test Plan:
1. rst=1 for 2 cycles, then we=1, imm=0 for 3 cycles -> instr_addr 0,4,8,0xC; halt=0.
2. At pc=0x10: stall=1 with imm=1, mode=00, imm_addr=0x40 -> pc stays 0x10. Then stall=0, imm held -> pc=0x40.
3. At pc=0x40: call mode=10, imm_addr=0xFFFFFFF0 -> pc=0x30, ras_empty=0. Then return mode=11 -> pc=0x44, ras_empty=1.
4. Five calls with RAS_DEPTH=4 from pcs 0x0,0x8,0x10,0x18,0x20 (offset +8) -> ras_full=1. Four returns yield 0x24,0x1C,0x14,0x0C. A fifth return -> halt=1, err=1, pc holds.
5. Absolute redirect imm_addr=0x6 -> halt=1, err=1, instr_addr unchanged. Then we, imm and stall toggled for 4 cycles -> nothing changes. Then rst pulsed mid-cycle -> instr_addr=0, halt=0 immediately.
6. Sequential run from 0x3F8 with MEM_BYTES=0x400 -> pc=0x3FC, then next edge halt=1, err=0, pc stays 0x3FC.
